token_precision_quantizer: RTL and testbench
============================================

Name: token_precision_quantizer

Overview:
- Consumer side of the per-token precision codes (0=int4, 1=int8, 2=fp16) produced by the attention precision assigner.
- On start, latches a flattened value matrix V (L tokens x D elements, signed Q1.15) and the L codes.
- Streams every element out, fake-quantised to its token's precision, over a valid/ready interface to the mixed-precision matmul.

Parameters:
DATA_WIDTH, 16, element width in bits; signed Q1.15; quantisation rules below assume 16
L, 8, number of tokens
D, 4, elements per token (embedding dimension)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request; sampled only in S_IDLE
busy  output  1  high in every state except S_IDLE
done  output  1  one-cycle pulse after the final handshake
token_precision  input  2 x [0:L-1]  unpacked array of per-token codes; sampled with start
V_in  input  DATA_WIDTH*L*D  flattened V; element (t,d) occupies bits [(t*D+d+1)*DATA_WIDTH-1 -: DATA_WIDTH]
out_valid  output  1  output beat valid
out_ready  input  1  downstream accept
out_data  output  DATA_WIDTH  quantised element
out_token  output  $clog2(L)  token index t of the current beat
out_elem  output  $clog2(D)  element index d of the current beat
out_prec  output  2  effective code applied to the current beat
out_last  output  1  high when d==D-1
code_err  output  1  sticky; set when any latched code==3; cleared on the next accepted start

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_token=0, out_elem=0, out_prec=0, out_last=0, code_err=0. FSM returns to S_IDLE.
- FSM states: S_IDLE, S_LOAD, S_EMIT, S_DONE.
- S_IDLE:
  - start=1: register V_in and token_precision; clear code_err; go to S_LOAD.
  - start=0: stay in S_IDLE.
- S_LOAD:
  - Set t=0, d=0; set code_err if any latched code==3.
  - Go to S_EMIT.
- S_EMIT:
  - out_valid=1; outputs are driven from registers.
  - out_data, out_prec and out_last hold stable while out_ready=0.
  - On out_valid&&out_ready, advance d; on d==D-1, wrap d to 0 and increment t.
  - On the handshake where t==L-1 and d==D-1, go to S_DONE.
- S_DONE: done=1 for one cycle, out_valid=0, then go to S_IDLE.
- Latency and throughput:
  - Start seen at edge k: first out_valid at edge k+2.
  - With out_ready held high: one beat per cycle, L*D beats total.
  - done asserts the cycle after the last handshake.
- Element order is token-major: t outer, d inner.
- Quantisation of element x:
  - Code 2 (fp16): passthrough.
  - Code 1 (int8): y = x + 0x0080. If x>=0 and the add overflows, result = 0x7F00. Otherwise result = {y[15:8], 8'h00}.
  - Code 0 (int4): y = x + 0x0800. If x>=0 and the add overflows, result = 0x7000. Otherwise result = {y[15:12], 12'h000}.
  - Negative values never saturate; use a 17-bit add to detect overflow.
  - Code 3: treated as code 2, and out_prec reports 2.
- start while busy is ignored. The latched data is unaffected by V_in or token_precision changes after the load.
- Reset mid-stream aborts immediately; no done is issued.
- L=1 or D=1 are legal; out_last is then always 1 when D=1.

Optional Feature:
- Macro: QUANT_ROUND_EN.
- Defined: round-to-nearest with saturation, exactly as specified above.
- Undefined: pure truncation. Code 1 gives {x[15:8], 8'h00}; code 0 gives {x[15:12], 12'h000}. No saturation logic is present.

Decomposition:
- Shared package tva_prec_pkg:
  - typedef prec_code_t as enum logic [1:0] {PREC_INT4=0, PREC_INT8=1, PREC_FP16=2, PREC_RSVD=3}.
  - Localparams for the saturation constants 0x7F00 and 0x7000.
- Sub-module prec_quant_unit: purely combinational (x, code) -> (y, eff_code). It holds the macro-dependent rounding so the FSM stays unchanged.

Test Plan:
- All codes 2, V[t][d] = t*16+d, out_ready=1 -> 32 beats, out_data equals V in token-major order, out_last on d=3, done pulses the cycle after beat 31.
- Token 0 code 1, x=0x12C0 -> 0x1300 with rounding (0x1200 when QUANT_ROUND_EN is undefined); x=0x7FF0 -> 0x7F00 (saturation).
- Token 1 code 0, x=0x1800 -> 0x2000; x=0x7FFF -> 0x7000; x=0x8000 -> 0x8000.
- out_ready toggles 1,0,0,1 during the stream -> no beat is lost or duplicated; out_data is held stable during the stall cycles; beat count is 32.
- Token 3 code 3 -> its beats are passthrough with out_prec=2; code_err=1 remains set until the next start.
- Assert rst_n low at beat 10 -> all outputs return to their reset values, no done pulse; a new start then produces a complete 32-beat stream.

Source files
------------

// File: rtl/tva_prec_pkg.sv
// Shared precision codes and saturation constants for the
// token precision quantizer slice.
package tva_prec_pkg;

   typedef enum logic [1:0] {
      PREC_INT4 = 2'd0,
      PREC_INT8 = 2'd1,
      PREC_FP16 = 2'd2,
      PREC_RSVD = 2'd3
   } prec_code_t;

   localparam logic [15:0] SAT_INT8 = 16'h7F00;
   localparam logic [15:0] SAT_INT4 = 16'h7000;

endpackage

// File: rtl/prec_quant_unit.sv
// Combinational fake-quantiser for one Q1.15 element.
// QUANT_ROUND_EN selects round-to-nearest with saturation, else truncation.
module prec_quant_unit
   import tva_prec_pkg::*;
(
   input  logic [15:0] i_x,
   input  prec_code_t  i_code,
   output logic [15:0] o_y,
   output prec_code_t  o_code
);

   logic [15:0] w_q8;
   logic [15:0] w_q4;

`ifdef QUANT_ROUND_EN
   // Only the kept bits plus a sign guard are summed; the
   // guard/sign disagreement is the 17-bit overflow condition.
   logic [8:0] w_s8;
   logic [4:0] w_s4;
   logic       w_sat8;
   logic       w_sat4;

   assign w_s8   = {i_x[15], i_x[15:8]} + 9'(i_x[7]);
   assign w_s4   = {i_x[15], i_x[15:12]} + 5'(i_x[11]);
   assign w_sat8 = w_s8[8] ^ w_s8[7];
   assign w_sat4 = w_s4[4] ^ w_s4[3];
   assign w_q8   = w_sat8 ? SAT_INT8 : {w_s8[7:0], 8'h00};
   assign w_q4   = w_sat4 ? SAT_INT4 : {w_s4[3:0], 12'h000};
`else
   assign w_q8 = {i_x[15:8], 8'h00};
   assign w_q4 = {i_x[15:12], 12'h000};
`endif

   always_comb begin
      o_y    = i_x;
      o_code = PREC_FP16;
      unique case (1'b1)
         (i_code == PREC_INT4): begin
            o_y    = w_q4;
            o_code = PREC_INT4;
         end
         (i_code == PREC_INT8): begin
            o_y    = w_q8;
            o_code = PREC_INT8;
         end
         (i_code == PREC_FP16),
         (i_code == PREC_RSVD): begin
            o_y    = i_x;
            o_code = PREC_FP16;
         end
      endcase
   end

endmodule

// File: rtl/token_precision_quantizer.sv
// Latches V and per-token codes, streams fake-quantised elements.
// Rounding mode is selected by QUANT_ROUND_EN (see prec_quant_unit).
module token_precision_quantizer
   import tva_prec_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int L          = 8,
   parameter int D          = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   input  logic [1:0]                   token_precision [0:L-1],
   input  logic [DATA_WIDTH*L*D-1:0]    V_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [(L>1?$clog2(L):1)-1:0] out_token,
   output logic [(D>1?$clog2(D):1)-1:0] out_elem,
   output logic [1:0]                   out_prec,
   output logic                         out_last,
   output logic                         code_err
);

   localparam int TW = (L > 1) ? $clog2(L) : 1;
   localparam int EW = (D > 1) ? $clog2(D) : 1;

   typedef enum logic [1:0] {
      S_IDLE, S_LOAD, S_EMIT, S_DONE
   } state_t;

   state_t                      r_state;
   state_t                      w_next;
   logic [DATA_WIDTH*L*D-1:0]   r_v;
   prec_code_t                  r_codes [0:L-1];
   logic [TW-1:0]               r_t;
   logic [EW-1:0]               r_d;
   logic [DATA_WIDTH-1:0]       r_data;
   prec_code_t                  r_oprec;
   logic                        r_last;
   logic                        r_err;

   logic                        w_hs;
   logic                        w_fin;
   logic                        w_ld;
   logic                        w_any_rsvd;
   logic [TW-1:0]               w_nt;
   logic [EW-1:0]               w_nd;
   int                          w_idx;
   logic [DATA_WIDTH-1:0]       w_x;
   logic [DATA_WIDTH-1:0]       w_y;
   prec_code_t                  w_code;

   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign out_valid = (r_state == S_EMIT);
   assign out_data  = r_data;
   assign out_token = r_t;
   assign out_elem  = r_d;
   assign out_prec  = r_oprec;
   assign out_last  = r_last;
   assign code_err  = r_err;

   assign w_hs  = out_valid && out_ready;
   assign w_fin = (r_t == TW'(L-1)) && (r_d == EW'(D-1));
   assign w_ld  = (r_state == S_LOAD) || (w_hs && !w_fin);

   always_comb begin
      w_any_rsvd = 1'b0;
      for (int i = 0; i < L; i++)
         if (r_codes[i] == PREC_RSVD) w_any_rsvd = 1'b1;
   end

   // Index of the beat to present next; its value is registered.
   always_comb begin
      w_nt = r_t;
      w_nd = r_d;
      if (r_state == S_LOAD) begin
         w_nt = '0;
         w_nd = '0;
      end else if (w_hs) begin
         if (r_d == EW'(D-1)) begin
            w_nd = '0;
            w_nt = r_t + TW'(1);
         end else begin
            w_nd = r_d + EW'(1);
         end
      end
   end

   assign w_idx = int'(w_nt) * D + int'(w_nd);
   assign w_x   = r_v[w_idx*DATA_WIDTH +: DATA_WIDTH];

   prec_quant_unit u_quant (
      .i_x    (w_x),
      .i_code (r_codes[w_nt]),
      .o_y    (w_y),
      .o_code (w_code)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (start) w_next = S_LOAD;
         S_LOAD: w_next = S_EMIT;
         S_EMIT: if (w_hs && w_fin) w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v     <= '0;
         r_t     <= '0;
         r_d     <= '0;
         r_data  <= '0;
         r_oprec <= PREC_INT4;
         r_last  <= 1'b0;
         r_err   <= 1'b0;
         for (int i = 0; i < L; i++) r_codes[i] <= PREC_FP16;
      end else begin
         if (r_state == S_IDLE && start) begin
            r_v   <= V_in;
            r_err <= 1'b0;
            for (int i = 0; i < L; i++)
               r_codes[i] <= prec_code_t'(token_precision[i]);
         end
         if (r_state == S_LOAD) r_err <= w_any_rsvd;
         if (w_ld) begin
            r_t     <= w_nt;
            r_d     <= w_nd;
            r_data  <= w_y;
            r_oprec <= w_code;
            r_last  <= (w_nd == EW'(D-1));
         end
      end
   end

endmodule

// File: tb/tb_token_precision_quantizer.sv
// Directed bench for token_precision_quantizer; honours QUANT_ROUND_EN
// when choosing expected rounding results.
module tb_token_precision_quantizer;

   localparam int DW = 16;
   localparam int L  = 8;
   localparam int D  = 4;
   localparam int N  = L * D;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            out_ready = 1'b0;
   logic [1:0]      tp [0:L-1];
   logic [DW*N-1:0] vin;
   logic            busy, done, out_valid, out_last, code_err;
   logic [DW-1:0]   out_data;
   logic [2:0]      out_token;
   logic [1:0]      out_elem;
   logic [1:0]      out_prec;

   int errs   = 0;
   int checks = 0;

   logic [15:0] bd [N];
   logic [2:0]  bt [N];
   logic [1:0]  be [N];
   logic [1:0]  bp [N];
   logic        bl [N];
   logic [15:0] ed [N];
   logic [1:0]  ep [N];
   int          nbeats;

   always #5 clk = ~clk;

   token_precision_quantizer #(.DATA_WIDTH(DW), .L(L), .D(D)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .token_precision (tp),
      .V_in            (vin),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_token       (out_token),
      .out_elem        (out_elem),
      .out_prec        (out_prec),
      .out_last        (out_last),
      .code_err        (code_err)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      check({tag, "_busy"},  32'(busy), 0);
      check({tag, "_done"},  32'(done), 0);
      check({tag, "_valid"}, 32'(out_valid), 0);
      check({tag, "_data"},  32'(out_data), 0);
      check({tag, "_tok"},   32'(out_token), 0);
      check({tag, "_elem"},  32'(out_elem), 0);
      check({tag, "_prec"},  32'(out_prec), 0);
      check({tag, "_last"},  32'(out_last), 0);
      check({tag, "_err"},   32'(code_err), 0);
   endtask

   // Base matrix: element (t,d) = t*16+d, all codes fp16.
   task automatic load_base();
      for (int t = 0; t < L; t++) begin
         tp[t] = 2'd2;
         for (int d = 0; d < D; d++) begin
            vin[(t*D+d)*DW +: DW] = 16'(t*16 + d);
            ed[t*D+d] = 16'(t*16 + d);
            ep[t*D+d] = 2'd2;
         end
      end
   endtask

   // rmode 0: ready always high; rmode 1: ready 1,0,0,1 repeating.
   // abort_at >= 0 pulls reset after that many beats.
   task automatic run(input string tag, input int rmode, input bit poke,
                      input int abort_at, input logic exp_err);
      logic        stall;
      logic [15:0] h_data;
      logic [1:0]  h_prec;
      logic        h_last;
      int          last_hs;
      int          done_cyc;
      bit          poked;
      stall = 1'b0; h_data = '0; h_prec = '0; h_last = 1'b0;
      last_hs = -10; done_cyc = -1; poked = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_k1"},  32'(busy), 1);
      check({tag, "_valid_k1"}, 32'(out_valid), 0);
      if (poke) begin
         for (int i = 0; i < N; i++) vin[i*DW +: DW] = 16'hAAAA;
         for (int t = 0; t < L; t++) tp[t] = 2'd3;
      end
      @(negedge clk);
      check({tag, "_valid_k2"}, 32'(out_valid), 1);
      check({tag, "_err"},      32'(code_err), 32'(exp_err));
      nbeats = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (abort_at >= 0 && nbeats == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk_reset_outs({tag, "_abort"});
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check({tag, "_nodone"}, 32'(done), 0);
            end
            out_ready = 1'b0;
            rst_n = 1'b1;
            return;
         end
         if (stall && out_valid) begin
            check({tag, "_hold_data"}, 32'(out_data), 32'(h_data));
            check({tag, "_hold_prec"}, 32'(out_prec), 32'(h_prec));
            check({tag, "_hold_last"}, 32'(out_last), 32'(h_last));
         end
         out_ready = (rmode == 0) ? 1'b1 : (cyc % 4 == 0 || cyc % 4 == 3);
         start = 1'b0;
         if (poke && !poked && nbeats == 5) begin
            start = 1'b1;
            poked = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (nbeats < N) begin
               bd[nbeats] = out_data;
               bt[nbeats] = out_token;
               be[nbeats] = out_elem;
               bp[nbeats] = out_prec;
               bl[nbeats] = out_last;
            end
            nbeats++;
            last_hs = cyc;
         end
         stall  = out_valid && !out_ready;
         h_data = out_data;
         h_prec = out_prec;
         h_last = out_last;
         @(negedge clk);
      end
      start = 1'b0;
      out_ready = 1'b0;
      check({tag, "_beats"},    32'(nbeats), 32'(N));
      check({tag, "_done_lat"}, 32'(done_cyc), 32'(last_hs + 1));
      check({tag, "_err_end"},  32'(code_err), 32'(exp_err));
      @(negedge clk);
      check({tag, "_done_1cy"}, 32'(done), 0);
      check({tag, "_idle"},     32'(busy), 0);
      for (int i = 0; i < N && i < nbeats; i++) begin
         check($sformatf("%s_d%0d", tag, i), 32'(bd[i]), 32'(ed[i]));
         check($sformatf("%s_t%0d", tag, i), 32'(bt[i]), 32'(i / D));
         check($sformatf("%s_e%0d", tag, i), 32'(be[i]), 32'(i % D));
         check($sformatf("%s_p%0d", tag, i), 32'(bp[i]), 32'(ep[i]));
         check($sformatf("%s_l%0d", tag, i), 32'(bl[i]),
               32'(i % D == D - 1));
      end
   endtask

   initial begin
      logic [15:0] x0 [4];
      logic [15:0] x1 [4];
      logic [15:0] q0 [4];
      logic [15:0] q1 [4];
      x0 = '{16'h12C0, 16'h7FF0, 16'h0000, 16'hFFF0};
      x1 = '{16'h1800, 16'h7FFF, 16'h8000, 16'h0123};
`ifdef QUANT_ROUND_EN
      q0 = '{16'h1300, 16'h7F00, 16'h0000, 16'h0000};
      q1 = '{16'h2000, 16'h7000, 16'h8000, 16'h0000};
`else
      q0 = '{16'h1200, 16'h7F00, 16'h0000, 16'hFF00};
      q1 = '{16'h1000, 16'h7000, 16'h8000, 16'h0000};
`endif
      load_base();
      repeat (2) @(negedge clk);
      chk_reset_outs("rst");
      rst_n = 1'b1;
      @(negedge clk);

      run("pass", 0, 1'b0, -1, 1'b0);

      load_base();
      tp[0] = 2'd1;
      tp[1] = 2'd0;
      tp[3] = 2'd3;
      for (int d = 0; d < D; d++) begin
         vin[(0*D+d)*DW +: DW] = x0[d];
         vin[(1*D+d)*DW +: DW] = x1[d];
         vin[(3*D+d)*DW +: DW] = 16'h9ABC + 16'(d);
         ed[0*D+d] = q0[d];
         ed[1*D+d] = q1[d];
         ed[3*D+d] = 16'h9ABC + 16'(d);
         ep[0*D+d] = 2'd1;
         ep[1*D+d] = 2'd0;
         ep[3*D+d] = 2'd2;
      end
      run("mix", 1, 1'b1, -1, 1'b1);
      repeat (3) @(negedge clk);
      check("err_sticky", 32'(code_err), 1);

      load_base();
      run("abort", 0, 1'b0, 10, 1'b0);
      @(negedge clk);
      run("restart", 0, 1'b0, -1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
